// File: rtl/timer_pkg.sv
// timer_pkg: shared widths and FSM state encoding for interval_timer_ctrl.
package timer_pkg;
    localparam int CNT_W      = 4;
    localparam int TICK_CNT_W = 8;
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/up_counter_load.sv
// up_counter_load: 4-bit up counter with synchronous load taking priority over increment.
module up_counter_load
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] data_in,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= data_in;
        else count <= count + 1'b1;
endmodule

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: one-shot / periodic interval timer FSM driving a loadable counter.
// Define TIMER_TICK_CNT_EN to add the saturating tick_count output.
module interval_timer_ctrl
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] start_val,
    input  logic [CNT_W-1:0] end_val,
    output logic             ready,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [CNT_W-1:0] count
`ifdef TIMER_TICK_CNT_EN
    ,output logic [TICK_CNT_W-1:0] tick_count
`endif
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_start, r_end, w_data;
    logic             r_per, w_term, w_accept, w_reload, w_inc;
    assign w_term   = count == r_end;
    assign ready    = r_state == IDLE;
    assign busy     = r_state == LOAD || r_state == RUN;
    assign tick     = r_state == RUN && w_term;
    assign done     = r_state == DONE && !stop;
    assign w_accept = ready && start && !stop;
    assign w_reload = !stop && (r_state == LOAD || (tick && r_per));
    assign w_inc    = r_state == RUN && !stop && !w_term;
    // Holding is a self-load, so the counter only needs load/data_in.
    assign w_data   = w_reload ? r_start : count;
    always_comb
        w_next = r_state == IDLE ? (w_accept ? LOAD : IDLE) :
                 stop            ? IDLE :
                 r_state == LOAD ? RUN :
                 r_state == RUN  ? ((w_term && !r_per) ? DONE : RUN) : IDLE;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_start <= '0;
            r_end   <= '0;
            r_per   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_start <= start_val;
                r_end   <= end_val;
                r_per   <= periodic;
            end
        end
    up_counter_load u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (!w_inc),
        .data_in (w_data),
        .count   (count)
    );
`ifdef TIMER_TICK_CNT_EN
    logic [TICK_CNT_W-1:0] r_tick_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_tick_cnt <= '0;
        else if (w_accept) r_tick_cnt <= '0;
        else if (tick && r_tick_cnt != '1) r_tick_cnt <= r_tick_cnt + 1'b1;
    assign tick_count = r_tick_cnt;
`endif
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed self-checking bench for interval_timer_ctrl.
module tb_interval_timer_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, stop, periodic;
    logic [3:0] start_val, end_val;
    logic       ready, busy, tick, done;
    logic [3:0] count;
`ifdef TIMER_TICK_CNT_EN
    logic [7:0] tick_count;
`endif
    int checks = 0;
    int errors = 0;

    interval_timer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .start_val (start_val),
        .end_val   (end_val),
        .ready     (ready),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .count     (count)
`ifdef TIMER_TICK_CNT_EN
        ,.tick_count(tick_count)
`endif
    );

    always #5 clk = ~clk;

    // Pulses start for one cycle from a negedge; returns at the negedge with the DUT in LOAD.
    task automatic go(input logic [3:0] s, input logic [3:0] e, input logic p);
        start_val = s; end_val = e; periodic = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; start_val = 4'h5; end_val = 4'hA;
        #1;
        checks++;
        if ({ready, busy, tick, done, count} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_state got rdy/busy/tick/done/cnt=%b exp 10000000", {ready, busy, tick, done, count});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, busy, count} !== 6'b10_0000) begin
            errors++;
            $display("FAIL reset_idle got rdy/busy/cnt=%b exp 100000", {ready, busy, count});
        end
    endtask

    task automatic test_oneshot;
        go(4'd3, 4'd6, 1'b0);
        checks++;
        if ({ready, busy} !== 2'b01) begin errors++; $display("FAIL oneshot_load got rdy/busy=%b exp 01", {ready, busy}); end
        start_val = 4'd0; end_val = 4'd15; periodic = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (count !== 4'(3 + i) || tick !== (i == 3) || busy !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_run i=%0d got cnt=%0d tick=%b busy=%b exp cnt=%0d tick=%b busy=1", i, count, tick, busy, 3 + i, i == 3);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, ready, count} !== 7'b100_0110) begin
            errors++;
            $display("FAIL oneshot_done got done/busy/rdy/cnt=%b exp 1000110", {done, busy, ready, count});
        end
        @(negedge clk);
        checks++;
        if ({ready, done} !== 2'b10) begin errors++; $display("FAIL oneshot_idle got rdy/done=%b exp 10", {ready, done}); end
    endtask

    task automatic test_periodic_wrap;
        logic [3:0] seq [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        go(4'd14, 4'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (count !== seq[i % 4] || tick !== (i % 4 == 3) || done !== 1'b0) begin
                errors++;
                $display("FAIL wrap_run i=%0d got cnt=%0d tick=%b done=%b exp cnt=%0d tick=%b done=0", i, count, tick, done, seq[i % 4], i % 4 == 3);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({ready, busy, done, count} !== 7'b100_0001) begin
            errors++;
            $display("FAIL wrap_stop_at_terminal got rdy/busy/done/cnt=%b exp 1000001", {ready, busy, done, count});
        end
    endtask

    task automatic test_equal;
        go(4'd9, 4'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (count !== 4'd9 || tick !== 1'b1) begin
                errors++;
                $display("FAIL equal_run i=%0d got cnt=%0d tick=%b exp cnt=9 tick=1", i, count, tick);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({ready, tick, count} !== 6'b10_1001) begin errors++; $display("FAIL equal_stop got rdy/tick/cnt=%b exp 101001", {ready, tick, count}); end
    endtask

    task automatic test_stop;
        go(4'd2, 4'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (count !== 4'(2 + i) || tick !== 1'b0) begin
                errors++;
                $display("FAIL stop_run i=%0d got cnt=%0d tick=%b exp cnt=%0d tick=0", i, count, tick, 2 + i);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ready, busy, tick, done, count} !== 8'b1000_0101) begin
                errors++;
                $display("FAIL stop_hold i=%0d got rdy/busy/tick/done/cnt=%b exp 10000101", i, {ready, busy, tick, done, count});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stop_at_terminal;
        go(4'd1, 4'd3, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({tick, count} !== 5'b1_0011) begin errors++; $display("FAIL term_tick got tick/cnt=%b exp 10011", {tick, count}); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({ready, done, count} !== 6'b10_0011) begin errors++; $display("FAIL term_stop got rdy/done/cnt=%b exp 100011", {ready, done, count}); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL term_no_done got done=%b exp 0", done); end
    endtask

    task automatic test_reset_mid_run;
        go(4'd0, 4'd15, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (count !== 4'(i)) begin errors++; $display("FAIL busy_start i=%0d got cnt=%0d exp %0d", i, count, i); end
            if (i == 3) begin start = 1'b1; start_val = 4'd2; end
        end
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done, count} !== 7'b100_0000) begin
            errors++;
            $display("FAIL async_reset got rdy/busy/done/cnt=%b exp 1000000", {ready, busy, done, count});
        end
        @(negedge clk);
        rst = 1'b0;
        go(4'd3, 4'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({tick, count} !== 5'b1_0100) begin errors++; $display("FAIL post_reset_tick got tick/cnt=%b exp 10100", {tick, count}); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL post_reset_done got done=%b exp 1", done); end
        @(negedge clk);
    endtask

`ifdef TIMER_TICK_CNT_EN
    task automatic test_tick_cnt;
        go(4'd0, 4'd0, 1'b1);
        checks++;
        if (tick_count !== 8'd0) begin errors++; $display("FAIL tick_cnt_start got %0d exp 0", tick_count); end
        repeat (10) @(negedge clk);
        checks++;
        if (tick_count !== 8'd9) begin errors++; $display("FAIL tick_cnt_mid got %0d exp 9", tick_count); end
        repeat (290) @(negedge clk);
        checks++;
        if (tick_count !== 8'd255) begin errors++; $display("FAIL tick_cnt_sat got %0d exp 255", tick_count); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        go(4'd5, 4'd6, 1'b1);
        checks++;
        if (tick_count !== 8'd0) begin errors++; $display("FAIL tick_cnt_clear got %0d exp 0", tick_count); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_oneshot;
        test_periodic_wrap;
        test_equal;
        test_stop;
        test_stop_at_terminal;
        test_reset_mid_run;
`ifdef TIMER_TICK_CNT_EN
        test_tick_cnt;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on posedge.
REQ-002 SHALL have rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL have start  in  1  request to begin timing; accepted only when ready=1.
REQ-004 SHALL have stop  in  1  abort request; effective in any non-IDLE state.
REQ-005 SHALL have periodic  in  1  1 = auto-reload mode, 0 = one-shot; sampled with start.
REQ-006 SHALL have start_val  in  4  counter load value; sampled with start.
REQ-007 SHALL have end_val  in  4  terminal count value; sampled with start.
REQ-008 SHALL have ready  out  1  high only in IDLE.
REQ-009 SHALL have busy  out  1  high in LOAD or RUN.
REQ-010 SHALL have tick  out  1  one-cycle pulse at terminal count.
REQ-011 SHALL have done  out  1  one-cycle pulse on one-shot completion.
REQ-012 SHALL have count  out  4  current value of the controlled 4-bit loadable up counter.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: start=1 and stop=0 -> capture start_val, end_val, periodic; go to LOAD; start ignored otherwise.
REQ-015 LOAD: assert counter load with captured start_val; count=start_val on next cycle; go to RUN.
REQ-016 RUN: counter increments by 1 each cycle, modulo 16 (4'hF -> 4'h0 wrap).
REQ-017 tick SHALL be high in a RUN cycle iff count == captured end_val; it is decoded from registers, with no input-to-output path.
REQ-018 RUN at terminal, periodic=1: assert counter load the same cycle; count=start_val next cycle; remain in RUN; period = ((end_val - start_val) mod 16) + 1 cycles.
REQ-019 RUN at terminal, periodic=0: go to DONE; counter holds its value.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 stop=1 in LOAD, RUN or DONE -> IDLE next cycle; no tick or done pulse that cycle; count holds.
REQ-022 stop and terminal in the same RUN cycle: tick still asserts that cycle; stop wins the transition to IDLE.
REQ-023 start_val == end_val SHALL produce tick on the first RUN cycle.
REQ-024 start_val > end_val SHALL count through the wrap.
REQ-025 Changes to start_val, end_val or periodic outside an accepted start SHALL have no effect.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE and count=0, tick=0, done=0, busy=0, ready=1, and clear the captured registers.
REQ-027 Reset mid-RUN SHALL abort without a done pulse; the first accepted start after release behaves as from power-up.

Configuration
REQ-028 Macro TIMER_TICK_CNT_EN defined: add output tick_count (8 bits), incremented on every tick, saturating at 8'hFF, cleared by rst and by each accepted start.
REQ-029 Macro TIMER_TICK_CNT_EN undefined: no tick_count port and no associated logic; all other behaviour identical.

Structure
REQ-030 Shared package timer_pkg SHALL hold the state typedef (IDLE, LOAD, RUN, DONE), CNT_W=4 and TICK_CNT_W=8.
REQ-031 The counter SHALL be a sub-module up_counter_load: clk, rst, load, data_in[3:0], count[3:0], with load priority over increment.
REQ-032 interval_timer_ctrl SHALL contain the FSM, capture registers and pulse/tick-count logic only.

Verification
REQ-033 One-shot: start=1, start_val=3, end_val=6, periodic=0 -> count 3,4,5,6; tick with count=6; done next cycle; ready after that.
REQ-034 Periodic wrap: start_val=14, end_val=1, periodic=1 -> count 14,15,0,1,14,...; tick every 4 cycles at count=1.
REQ-035 Equal values: start_val=end_val=9, periodic=1 -> tick on every RUN cycle; count stays 9.
REQ-036 Stop: stop=1 at count=5 with start_val=2, end_val=10 -> IDLE next cycle; count holds 5; no tick or done.
REQ-037 Async reset mid-RUN at count=7 -> immediately count=0, ready=1, busy=0, no done; start while busy is ignored.
REQ-038 With TIMER_TICK_CNT_EN: periodic, start_val=0, end_val=0, run 300 cycles -> tick_count saturates at 255; a new start clears it to 0.
